sps_encoder: RTL



---
 rtl/sps_encoder_if.sv | 28 ++
 rtl/sps_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sps_encoder_if.sv
// Request, field and serial-stream signals between the SPS encoder and its user.
// The master side drives the request and bit_ready; the slave (encoder) drives the stream.
interface sps_encoder_if;
    logic        start;
    logic [7:0]  profile;
    logic [15:0] width;
    logic [15:0] height;
    logic [7:0]  fps;
    logic [1:0]  chroma_format;
    logic [3:0]  bit_depth;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic [7:0]  bit_count;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, profile, width, height, fps, chroma_format, bit_depth, bit_ready,
        input  bit_out, bit_valid, bit_count, busy, done, error
    );

    modport slave (
        input  start, profile, width, height, fps, chroma_format, bit_depth, bit_ready,
        output bit_out, bit_valid, bit_count, busy, done, error
    );
endinterface

// File: rtl/sps_encoder.sv
// Serialises an SPS header (u(8)/ue(v) fields) one bit per valid/ready transfer, MSB first.
// Each field state holds a code word and a remaining-bit count; bits above the word are leading zeros.
module sps_encoder #(
    parameter int unsigned MAX_DIM = 32'd8192
) (
    input  logic         clk,
    input  logic         reset,
    sps_encoder_if.slave sps_if
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_PROFILE, S_WIDTH, S_HEIGHT,
        S_FPS, S_CHROMA, S_BITDEPTH, S_DONE
    } state_t;

    localparam logic [16:0] MAX_DIM_W = 17'(MAX_DIM);

    state_t      state_q, state_d;
    logic [7:0]  prof_q, fps_q;
    logic [15:0] width_q, height_q;
    logic [1:0]  chroma_q;
    logic [3:0]  depth_q;
    logic [16:0] word_q, word_d;
    logic [5:0]  rem_q, rem_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic [7:0]  bit_count_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        load_s, xfer_s, accept_s, illegal_s;
    logic [16:0] code_s;

    // Total ue(v) length for code c = v+1: 2*bitlen(c)-1.
    function automatic logic [5:0] ue_len(input logic [16:0] c);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 17; i++) begin
            if (c[i]) n = 6'(i + 1);
        end
        return 6'((n << 1) - 6'd1);
    endfunction

    function automatic logic stream_bit(input logic [16:0] w, input logic [5:0] rem);
        logic [4:0] idx;
        idx = 5'(rem - 6'd1);
        if (rem == 6'd0 || rem > 6'd17) return 1'b0;
        else return w[idx];
    endfunction

    function automatic state_t next_field(input state_t s);
        case (s)
            S_PROFILE:  return S_WIDTH;
            S_WIDTH:    return S_HEIGHT;
            S_HEIGHT:   return S_FPS;
            S_FPS:      return S_CHROMA;
            S_CHROMA:   return S_BITDEPTH;
            S_BITDEPTH: return S_DONE;
            default:    return S_IDLE;
        endcase
    endfunction

    assign xfer_s    = bit_valid_q && sps_if.bit_ready;
    assign accept_s  = (state_q == S_IDLE) && sps_if.start;
    assign illegal_s = (width_q == 16'd0) || ({1'b0, width_q} > MAX_DIM_W) ||
                       (height_q == 16'd0) || ({1'b0, height_q} > MAX_DIM_W) ||
                       (depth_q < 4'd8);

    // Next state, field word/counter loading and next registered outputs.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rem_d   = rem_q;
        load_s  = 1'b0;
        code_s  = 17'd0;
        case (state_q)
            S_IDLE: begin
                if (sps_if.start) state_d = S_CHECK;
                else state_d = S_IDLE;
            end
            S_CHECK: begin
                if (illegal_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PROFILE;
                    load_s  = 1'b1;
                end
            end
            S_PROFILE, S_WIDTH, S_HEIGHT, S_FPS, S_CHROMA, S_BITDEPTH: begin
                if (xfer_s && rem_q == 6'd1) begin
                    state_d = next_field(state_q);
                    load_s  = (state_q != S_BITDEPTH);
                end else if (xfer_s) begin
                    rem_d = rem_q - 6'd1;
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Loading the next field here keeps bit_valid high across field boundaries.
        if (load_s) begin
            case (state_d)
                S_PROFILE: begin
                    word_d = {9'd0, prof_q};
                    rem_d  = 6'd8;
                end
                S_WIDTH: begin
                    code_s = {1'b0, width_q} + 17'd1;
                    word_d = code_s;
                    rem_d  = ue_len(code_s);
                end
                S_HEIGHT: begin
                    code_s = {1'b0, height_q} + 17'd1;
                    word_d = code_s;
                    rem_d  = ue_len(code_s);
                end
                S_FPS: begin
                    word_d = {9'd0, fps_q};
                    rem_d  = 6'd8;
                end
                S_CHROMA: begin
                    code_s = {15'd0, chroma_q} + 17'd1;
                    word_d = code_s;
                    rem_d  = ue_len(code_s);
                end
                S_BITDEPTH: begin
                    code_s = {13'd0, depth_q} - 17'd7;
                    word_d = code_s;
                    rem_d  = ue_len(code_s);
                end
                default: begin
                    word_d = word_q;
                    rem_d  = rem_q;
                end
            endcase
        end else begin
            code_s = 17'd0;
        end

        bit_valid_d = state_d inside {S_PROFILE, S_WIDTH, S_HEIGHT, S_FPS, S_CHROMA, S_BITDEPTH};
        bit_out_d   = bit_valid_d ? stream_bit(word_d, rem_d) : 1'b0;
        busy_d      = !(state_d inside {S_IDLE, S_DONE});
        done_d      = (state_d == S_DONE);
        error_d     = (state_q == S_CHECK) && illegal_s;
    end

    // State, latched request fields, bit counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prof_q      <= 8'd0;
            width_q     <= 16'd0;
            height_q    <= 16'd0;
            fps_q       <= 8'd0;
            chroma_q    <= 2'd0;
            depth_q     <= 4'd0;
            word_q      <= 17'd0;
            rem_q       <= 6'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_count_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            if (accept_s) begin
                prof_q      <= sps_if.profile;
                width_q     <= sps_if.width;
                height_q    <= sps_if.height;
                fps_q       <= sps_if.fps;
                chroma_q    <= sps_if.chroma_format;
                depth_q     <= sps_if.bit_depth;
                bit_count_q <= 8'd0;
            end else if (xfer_s) begin
                bit_count_q <= bit_count_q + 8'd1;
            end else begin
                bit_count_q <= bit_count_q;
            end
        end
    end

    assign sps_if.bit_out   = bit_out_q;
    assign sps_if.bit_valid = bit_valid_q;
    assign sps_if.bit_count = bit_count_q;
    assign sps_if.busy      = busy_q;
    assign sps_if.done      = done_q;
    assign sps_if.error     = error_q;

endmodule
